// File: rtl/fbw_row_sink.sv
// rtl/fbw_row_sink.sv - fbw responder: ping-pong line buffers copied row-wise into a double-buffered frame memory
// Frame flips wait for an idle copy engine and the display's end-of-frame pulse.
module fbw_row_sink #(
  parameter int N_ROWS   = 64,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 16,
  localparam int LR = $clog2(N_ROWS),
  localparam int LC = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LR-1:0]         fbw_row_addr,
  input  logic                  fbw_row_store,
  output logic                  fbw_row_rdy,
  input  logic                  fbw_row_swap,
  input  logic [BITDEPTH-1:0]   fbw_data,
  input  logic [LC-1:0]         fbw_col_addr,
  input  logic                  fbw_wren,
  input  logic                  frame_swap,
  output logic                  frame_rdy,
  output logic [LR+LC:0]        fb_addr,
  output logic [BITDEPTH-1:0]   fb_data,
  output logic                  fb_wren,
  output logic                  disp_frame,
  input  logic                  disp_frame_end
);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN} state_t;

  localparam logic [LC-1:0] LAST_COL = LC'(N_COLS - 1);

  state_t              state;
  logic                wsel;
  logic                flip_pending;
  logic [LR-1:0]       row;
  logic [LC-1:0]       col_cnt;
  logic [BITDEPTH-1:0] lbuf [2][N_COLS];

  logic swap_ok, store_ok, fswap_ok;
  assign swap_ok  = fbw_row_rdy & fbw_row_swap;
  assign store_ok = fbw_row_rdy & fbw_row_store;
  assign fswap_ok = frame_rdy & frame_swap;

  // Line buffer contents survive reset; pixel writes always land in the write buffer.
  always_ff @(posedge clk) begin
    if (fbw_wren) lbuf[wsel][fbw_col_addr] <= fbw_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wsel         <= 1'b0;
      flip_pending <= 1'b0;
      row          <= '0;
      col_cnt      <= '0;
      fbw_row_rdy  <= 1'b1;
      frame_rdy    <= 1'b1;
      fb_wren      <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      disp_frame   <= 1'b0;
    end else begin
      fb_wren <= 1'b0;
      if (fswap_ok) begin
        flip_pending <= 1'b1;
        frame_rdy    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (swap_ok) wsel <= ~wsel;
          if (store_ok) begin
            row         <= fbw_row_addr;
            col_cnt     <= '0;
            state       <= COPY;
            fbw_row_rdy <= 1'b0;
          end else if (flip_pending && disp_frame_end) begin
            disp_frame   <= ~disp_frame;
            flip_pending <= 1'b0;
            frame_rdy    <= 1'b1;
            fbw_row_rdy  <= 1'b1;
          end else if (fswap_ok) begin
            fbw_row_rdy <= 1'b0;
          end
        end
        COPY: begin
          // Read buffer is ~wsel; fb_data doubles as the RAM output register.
          fb_wren <= 1'b1;
          fb_addr <= {~disp_frame, row, col_cnt};
          fb_data <= lbuf[~wsel][col_cnt];
          if (col_cnt == LAST_COL) state <= DRAIN;
          else                     col_cnt <= col_cnt + LC'(1);
        end
        DRAIN: begin
          state       <= IDLE;
          fbw_row_rdy <= ~(flip_pending | fswap_ok);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbw_row_sink.sv
// tb/tb_fbw_row_sink.sv - directed/random bench for fbw_row_sink against a line-buffer/frame model
module tb_fbw_row_sink;
  localparam int N_ROWS = 64, N_COLS = 64, BITDEPTH = 16;
  localparam int LR = 6, LC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [LR-1:0]       fbw_row_addr;
  logic                fbw_row_store, fbw_row_rdy, fbw_row_swap;
  logic [BITDEPTH-1:0] fbw_data;
  logic [LC-1:0]       fbw_col_addr;
  logic                fbw_wren, frame_swap, frame_rdy;
  logic [LR+LC:0]      fb_addr;
  logic [BITDEPTH-1:0] fb_data;
  logic                fb_wren, disp_frame, disp_frame_end;

  fbw_row_sink #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BITDEPTH(BITDEPTH)) dut (
    .clk(clk), .rst(rst), .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store),
    .fbw_row_rdy(fbw_row_rdy), .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data),
    .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren), .frame_swap(frame_swap),
    .frame_rdy(frame_rdy), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren),
    .disp_frame(disp_frame), .disp_frame_end(disp_frame_end)
  );

  int checks = 0;
  int errors = 0;
  int wr_total = 0;

  logic [15:0] mlb [2][N_COLS];
  bit mwsel, mdisp, mpend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    fbw_row_store = 0; fbw_row_swap = 0; fbw_wren = 0;
    frame_swap = 0; disp_frame_end = 0; rst = 0;
  endtask

  // mode 0: data = col*3; mode 2: random data plus random overwrites (last write wins)
  task automatic write_buf(input int mode);
    for (int i = 0; i < N_COLS + 16; i++) begin
      int c;
      logic [15:0] d;
      if (i >= N_COLS && mode == 0) break;
      c = (i < N_COLS) ? i : int'($urandom_range(0, N_COLS - 1));
      d = (mode == 0) ? 16'(c * 3) : 16'($urandom);
      @(negedge clk);
      clear_inputs();
      fbw_wren = 1; fbw_col_addr = LC'(c); fbw_data = d;
      mlb[mwsel][c] = d;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
      chk("idle_wren", 32'(fb_wren), 0);
      chk("idle_rdy", 32'(fbw_row_rdy), 32'(!mpend));
    end
  endtask

  // Issue a store at the current negedge and follow the copy cycle by cycle.
  // wmode: 0 none, 1 constant wval, 2 random writes of every column during the copy.
  task automatic store_row(input logic [LR-1:0] row, input bit swap, input int wmode,
                           input logic [15:0] wval, input int fs_k, input int dfe_k,
                           input int ign_k, input int rst_k);
    logic [15:0] exp_d [N_COLS];
    bit wf;
    chk("rdy_before_store", 32'(fbw_row_rdy), 1);
    fbw_row_store = 1; fbw_row_swap = swap; fbw_row_addr = row;
    if (swap) mwsel = !mwsel;
    for (int c = 0; c < N_COLS; c++) exp_d[c] = mlb[!mwsel][c];
    wf = !mdisp;
    for (int k = 1; k <= N_COLS + 2; k++) begin
      @(negedge clk);
      clear_inputs();
      if (k == rst_k + 1) begin
        chk("rst_wren", 32'(fb_wren), 0);
        chk("rst_rdy", 32'(fbw_row_rdy), 1);
        chk("rst_frame_rdy", 32'(frame_rdy), 1);
        chk("rst_disp", 32'(disp_frame), 0);
        mwsel = 0; mdisp = 0; mpend = 0;
        return;
      end
      chk("copy_rdy", 32'(fbw_row_rdy), (k == N_COLS + 2) ? 32'(!mpend) : 0);
      chk("copy_wren", 32'(fb_wren), 32'(k >= 2 && k <= N_COLS + 1));
      if (k >= 2 && k <= N_COLS + 1) begin
        chk("fb_addr", 32'(fb_addr), (32'(wf) << (LR + LC)) | (32'(row) << LC) | 32'(k - 2));
        chk("fb_data", 32'(fb_data), 32'(exp_d[k-2]));
        wr_total++;
      end
      if (k <= N_COLS && wmode != 0) begin
        logic [15:0] d;
        d = (wmode == 1) ? wval : 16'($urandom);
        fbw_wren = 1; fbw_col_addr = LC'(k - 1); fbw_data = d;
        mlb[mwsel][k-1] = d;
      end
      if (k == fs_k) begin
        frame_swap = 1;
        mpend = 1;
      end
      if (k == dfe_k) disp_frame_end = 1;
      if (k == ign_k) begin
        fbw_row_store = 1; fbw_row_swap = 1; fbw_row_addr = LR'($urandom);
      end
      if (k == rst_k) rst = 1;
    end
  endtask

  task automatic flip_wait(input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      clear_inputs();
      chk("pend_rdy", 32'(fbw_row_rdy), 0);
      chk("pend_frame_rdy", 32'(frame_rdy), 0);
      chk("pend_disp", 32'(disp_frame), 32'(mdisp));
    end
    disp_frame_end = 1;
    @(negedge clk);
    clear_inputs();
    mdisp = !mdisp; mpend = 0;
    chk("flip_disp", 32'(disp_frame), 32'(mdisp));
    chk("flip_frame_rdy", 32'(frame_rdy), 1);
    chk("flip_rdy", 32'(fbw_row_rdy), 1);
  endtask

  initial begin
    int base;
    clear_inputs();
    fbw_row_addr = '0; fbw_col_addr = '0; fbw_data = '0;
    mwsel = 0; mdisp = 0; mpend = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(fbw_row_rdy), 1);
    chk("reset_frame_rdy", 32'(frame_rdy), 1);
    chk("reset_wren", 32'(fb_wren), 0);
    chk("reset_addr", 32'(fb_addr), 0);
    chk("reset_data", 32'(fb_data), 0);
    chk("reset_disp", 32'(disp_frame), 0);
    rst = 0;

    write_buf(0);
    store_row(6'd5, 1, 1, 16'hAAAA, -1, -1, -1, -1);
    store_row(6'd6, 1, 2, 16'h0000, -1, -1, 20, -1);
    idle(4);
    store_row(6'd7, 1, 0, 16'h0000, 5, 10, -1, -1);
    flip_wait(20);
    write_buf(2);
    store_row(6'd9, 1, 0, 16'h0000, -1, -1, -1, -1);

    write_buf(2);
    store_row(6'd10, 1, 0, 16'h0000, -1, -1, -1, 30);
    store_row(6'd11, 0, 0, 16'h0000, -1, -1, -1, -1);

    base = wr_total;
    for (int r = 0; r < N_ROWS; r++)
      store_row(LR'(r), 0, 2, 16'h0000, -1, -1, -1, -1);
    chk("b2b_total_writes", 32'(wr_total - base), 32'(N_ROWS * N_COLS));
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
